// File: rtl/adpll_pkg.sv
// Shared types and constants for the ADPLL phase/frequency detector.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } tdc_state_t;

  localparam int ERR_W_DEF = 8;

  // Largest positive value of a w-bit two's-complement phase error.
  function automatic int err_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser followed by a registered rising-edge detector.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;

  // Synchroniser chain, last-stage history and registered edge pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/phase_error_tdc.sv
// Counter-based PFD/TDC producing a signed phase error for the ADPLL loop filter.
// Optional lock detector enabled by defining LOCK_DETECT_EN.
module phase_error_tdc
  import adpll_pkg::*;
#(
  parameter int ERR_W       = ERR_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ref_in,
  input  logic             fb_in,
  input  logic             enable,
  output logic [ERR_W-1:0] phase_err,
  output logic             err_valid,
  output logic             up,
  output logic             dn,
  output logic             slip,
  output logic             locked
);

  localparam logic [ERR_W-2:0] MAX_MAG = (ERR_W-1)'(err_max(ERR_W));
  localparam logic [ERR_W-2:0] ONE     = (ERR_W-1)'(1);

  logic             rp_s, fp_s;
  tdc_state_t       state_q, state_d;
  logic [ERR_W-2:0] count_q, count_d, count_inc_s;
  logic             rep_vld_s, rep_neg_s, rep_slip_s;
  logic [ERR_W-2:0] rep_mag_s;
  logic [ERR_W-1:0] rep_val_s;
  logic [ERR_W-1:0] phase_err_q;
  logic             err_valid_q, slip_q, up_q, dn_q;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk(clk), .reset_n(reset_n), .sig_i(ref_in), .pulse_o(rp_s)
  );
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk(clk), .reset_n(reset_n), .sig_i(fb_in), .pulse_o(fp_s)
  );

  assign count_inc_s = (count_q == MAX_MAG) ? count_q : count_q + ONE;

  // State and cycle-count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: a coincident opposite edge closes the measurement, a same-side edge slips.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (!enable) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rp_s && !fp_s) begin
            state_d = REF_LEAD;
            count_d = ONE;
          end else if (fp_s && !rp_s) begin
            state_d = FB_LEAD;
            count_d = ONE;
          end else begin
            count_d = '0;
          end
        end
        REF_LEAD: begin
          if (fp_s && !rp_s) begin
            state_d = IDLE;
            count_d = '0;
          end else if (rp_s) begin
            count_d = ONE;
          end else begin
            count_d = count_inc_s;
          end
        end
        FB_LEAD: begin
          if (rp_s && !fp_s) begin
            state_d = IDLE;
            count_d = '0;
          end else if (fp_s) begin
            count_d = ONE;
          end else begin
            count_d = count_inc_s;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Report decode for the current cycle.
  always_comb begin
    rep_vld_s  = 1'b0;
    rep_neg_s  = 1'b0;
    rep_slip_s = 1'b0;
    rep_mag_s  = '0;
    if (enable) begin
      case (state_q)
        IDLE: begin
          rep_vld_s = rp_s & fp_s;
        end
        REF_LEAD: begin
          if (fp_s) begin
            rep_vld_s = 1'b1;
            rep_mag_s = count_q;
          end else if (rp_s) begin
            rep_vld_s  = 1'b1;
            rep_slip_s = 1'b1;
            rep_mag_s  = MAX_MAG;
          end else begin
            rep_vld_s = 1'b0;
          end
        end
        FB_LEAD: begin
          rep_neg_s = 1'b1;
          if (rp_s) begin
            rep_vld_s = 1'b1;
            rep_mag_s = count_q;
          end else if (fp_s) begin
            rep_vld_s  = 1'b1;
            rep_slip_s = 1'b1;
            rep_mag_s  = MAX_MAG;
          end else begin
            rep_vld_s = 1'b0;
          end
        end
        default: begin
          rep_vld_s = 1'b0;
        end
      endcase
    end else begin
      rep_vld_s = 1'b0;
    end
    rep_val_s = rep_neg_s ? ('0 - {1'b0, rep_mag_s}) : {1'b0, rep_mag_s};
  end

  // Registered outputs; phase_err holds between reports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_err_q <= '0;
      err_valid_q <= 1'b0;
      slip_q      <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
    end else begin
      err_valid_q <= rep_vld_s;
      slip_q      <= rep_slip_s;
      up_q        <= (state_d == REF_LEAD);
      dn_q        <= (state_d == FB_LEAD);
      if (rep_vld_s) begin
        phase_err_q <= rep_val_s;
      end
    end
  end

  assign phase_err = phase_err_q;
  assign err_valid = err_valid_q;
  assign slip      = slip_q;
  assign up        = up_q;
  assign dn        = dn_q;

`ifdef LOCK_DETECT_EN
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam logic [LCW-1:0] LOCK_CNT_V = LCW'(LOCK_CNT);

  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, in_lock_s;

  // Consecutive in-tolerance report counter, evaluated alongside the report itself.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    in_lock_s  = (rep_mag_s <= (ERR_W-1)'(LOCK_TOL)) && !rep_slip_s;
    if (!enable) begin
      lock_cnt_d = '0;
    end else if (rep_vld_s) begin
      if (in_lock_s) begin
        lock_cnt_d = (lock_cnt_q == LOCK_CNT_V) ? lock_cnt_q : lock_cnt_q + LCW'(1);
      end else begin
        lock_cnt_d = '0;
      end
    end else begin
      lock_cnt_d = lock_cnt_q;
    end
  end

  // Lock counter and indicator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= (lock_cnt_d == LOCK_CNT_V);
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_phase_error_tdc.sv
// Scoreboard bench for phase_error_tdc: expected reports queued at stimulus, checked on err_valid.
module tb_phase_error_tdc;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ref_in = 1'b0;
  logic       fb_in = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] phase_err;
  logic       err_valid, up, dn, slip, locked;

  typedef struct packed {
    logic [7:0] err;
    logic       slp;
    logic       lk;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  phase_error_tdc dut (
    .clk(clk), .reset_n(reset_n), .ref_in(ref_in), .fb_in(fb_in), .enable(enable),
    .phase_err(phase_err), .err_valid(err_valid), .up(up), .dn(dn), .slip(slip),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic lk_exp(input logic v);
`ifdef LOCK_DETECT_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  task automatic push(input logic [7:0] e, input logic s, input logic lk);
    exp_t x;
    x.err = e;
    x.slp = s;
    x.lk  = lk_exp(lk);
    exp_q.push_back(x);
  endtask

  // Scoreboard: every err_valid pops and checks one expected report.
  always @(negedge clk) begin
    if (reset_n && err_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_report", {24'd0, phase_err}, 32'hFFFF_FFFF);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("phase_err", {24'd0, phase_err}, {24'd0, x.err});
        check("slip", {31'd0, slip}, {31'd0, x.slp});
        check("locked", {31'd0, locked}, {31'd0, x.lk});
      end
    end
  end

  // One-cycle-wide edges at the given cycle offsets (-1 = none); counts up/dn cycles.
  task automatic run(input int r0, input int r1, input int f0, input int f1, input int len,
                     output int uc, output int dc);
    uc = 0;
    dc = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      ref_in = (i == r0) || (i == r1);
      fb_in  = (i == f0) || (i == f1);
      if (up) uc++;
      if (dn) dc++;
    end
    ref_in = 1'b0;
    fb_in  = 1'b0;
    check("drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int uc, dc;
    repeat (3) @(negedge clk);
    check("rst_phase_err", {24'd0, phase_err}, 32'd0);
    check("rst_outs", {27'd0, err_valid, up, dn, slip, locked}, 32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (3) @(negedge clk);

    push(8'h05, 1'b0, 1'b0);
    run(0, -1, 5, -1, 14, uc, dc);
    check("t1_up_cycles", uc, 32'd5);
    check("t1_dn_cycles", dc, 32'd0);

    push(8'hFD, 1'b0, 1'b0);
    run(3, -1, 0, -1, 14, uc, dc);
    check("t2_dn_cycles", dc, 32'd3);
    check("t2_up_cycles", uc, 32'd0);

    push(8'h00, 1'b0, 1'b0);
    run(0, -1, 0, -1, 10, uc, dc);
    check("t3_updn_cycles", uc + dc, 32'd0);

    push(8'h7F, 1'b1, 1'b0);
    push(8'h04, 1'b0, 1'b0);
    run(0, 20, 24, -1, 32, uc, dc);

    // Reset in the middle of a REF_LEAD measurement.
    @(negedge clk); ref_in = 1'b1;
    @(negedge clk); ref_in = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_up_before_rst", {31'd0, up}, 32'd1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_rst_phase_err", {24'd0, phase_err}, 32'd0);
    check("t5_rst_outs", {27'd0, err_valid, up, dn, slip, locked}, 32'd0);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_no_stale", {30'd0, up, dn}, 32'd0);
    push(8'h02, 1'b0, 1'b0);
    run(0, -1, 2, -1, 10, uc, dc);

    // Disabled: no report, phase_err held, no up/dn.
    enable = 1'b0;
    run(0, -1, 5, -1, 14, uc, dc);
    check("dis_up_cycles", uc + dc, 32'd0);
    check("dis_hold", {24'd0, phase_err}, 32'd2);
    enable = 1'b1;

    push(8'h81, 1'b1, 1'b0);
    push(8'hFE, 1'b0, 1'b0);
    run(22, -1, 0, 20, 32, uc, dc);

    push(8'h06, 1'b0, 1'b0);
    push(8'h03, 1'b0, 1'b0);
    run(0, 6, 6, 9, 16, uc, dc);

    push(8'h7F, 1'b0, 1'b0);
    run(0, -1, 140, -1, 150, uc, dc);

    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(8'h01, 1'b0, (k == 3));
      run(0, -1, 1, -1, 8, uc, dc);
    end
    push(8'h05, 1'b0, 1'b0);
    run(0, -1, 5, -1, 12, uc, dc);
    check("lock_final", {31'd0, locked}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
